// File: rtl/dac_stream_player.sv
// dac_stream_player: FIFO-buffered two-channel sample player feeding the DAC interface.
// Optional underrun event counter enabled by defining DAC_STREAM_PLAYER_UNDERRUN_CNT_EN.
module dac_stream_player #(
    parameter int FIFO_AW = 9,
    parameter int PREFILL = 256
) (
    input  logic               dac_clk_1x,
    input  logic               dac_rst,
    input  logic               enable_i,
    input  logic [15:0]        rate_i,
    input  logic [13:0]        offset_a_i,
    input  logic [13:0]        offset_b_i,
    input  logic [31:0]        s_tdata,
    input  logic               s_tvalid,
    output logic               s_tready,
    output logic [13:0]        dac_dat_a_o,
    output logic [13:0]        dac_dat_b_o,
    output logic               running_o,
    output logic               underrun_o,
    output logic [FIFO_AW:0]   fifo_level_o,
    output logic [15:0]        underrun_cnt_o
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0]   LVL_PRE  = (FIFO_AW+1)'(PREFILL);
    localparam logic [FIFO_AW:0]   LVL_ONE  = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREFILL,
        S_RUN,
        S_UNDERRUN
    } state_e;

    state_e             state_q, state_d;
    logic [27:0]        mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   level_q, level_d;
    logic [27:0]        rd_data_q, rd_data_d;
    logic               rd_vld_q, rd_vld_d;
    logic [13:0]        dat_a_q, dat_a_d;
    logic [13:0]        dat_b_q, dat_b_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               underrun_q, underrun_d;
    logic               running_q, running_d;

    logic full, empty, tick, flush, push, pop, clr, urun;
    logic unused_bits;

    assign unused_bits = ^{s_tdata[31:30], s_tdata[15:14]};

    function automatic logic [13:0] sat_add(input logic [13:0] s,
                                            input logic [13:0] o);
        logic [14:0] sum;
        sum = {s[13], s} + {o[13], o};
        if (sum[14] != sum[13]) begin
            return sum[14] ? 14'h2000 : 14'h1FFF;
        end
        return sum[13:0];
    endfunction

    always_comb begin
        full  = (level_q == LVL_FULL);
        empty = (level_q == '0);
        tick  = (cnt_q == '0);
        flush = !enable_i && (state_q != S_IDLE);
        push  = s_tvalid && !full && !flush;
        pop   = enable_i && (state_q == S_RUN) && tick && !empty;
        urun  = enable_i && (state_q == S_RUN) && tick && empty;
        clr   = enable_i && (state_q == S_IDLE);
    end

    // Counter sits at 0 outside RUN so every (re)entry ticks immediately
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (enable_i) state_d = S_PREFILL;
            end
            S_PREFILL: begin
                if (level_q >= LVL_PRE) state_d = S_RUN;
            end
            S_RUN: begin
                if (!tick) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (!empty) begin
                    cnt_d = rate_i;
                end else begin
                    state_d = S_UNDERRUN;
                end
            end
            S_UNDERRUN: begin
                if (level_q >= LVL_PRE) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
        if (!enable_i) state_d = S_IDLE;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    always_comb begin
        rd_vld_d  = pop;
        rd_data_d = pop ? mem_q[rd_ptr_q] : rd_data_q;
        dat_a_d   = dat_a_q;
        dat_b_d   = dat_b_q;
        if (state_q == S_IDLE || state_q == S_PREFILL) begin
            dat_a_d = '0;
            dat_b_d = '0;
        end else if (rd_vld_q) begin
            dat_a_d = sat_add(rd_data_q[13:0], offset_a_i);
            dat_b_d = sat_add(rd_data_q[27:14], offset_b_i);
        end
    end

    always_comb begin
        underrun_d = underrun_q;
        running_d  = (state_d == S_RUN);
        if (clr) begin
            underrun_d = 1'b0;
        end else if (urun) begin
            underrun_d = 1'b1;
        end
    end

    always_ff @(posedge dac_clk_1x) begin
        if (push) mem_q[wr_ptr_q] <= {s_tdata[29:16], s_tdata[13:0]};
    end

    always_ff @(posedge dac_clk_1x) begin
        if (dac_rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_data_q  <= '0;
            rd_vld_q   <= 1'b0;
            dat_a_q    <= '0;
            dat_b_q    <= '0;
            cnt_q      <= '0;
            underrun_q <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rd_data_q  <= rd_data_d;
            rd_vld_q   <= rd_vld_d;
            dat_a_q    <= dat_a_d;
            dat_b_q    <= dat_b_d;
            cnt_q      <= cnt_d;
            underrun_q <= underrun_d;
            running_q  <= running_d;
        end
    end

`ifdef DAC_STREAM_PLAYER_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if (clr) begin
            ucnt_d = '0;
        end else if (urun && ucnt_q != 16'hFFFF) begin
            ucnt_d = ucnt_q + 16'd1;
        end
    end

    always_ff @(posedge dac_clk_1x) begin
        if (dac_rst) begin
            ucnt_q <= '0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign underrun_cnt_o = ucnt_q;
`else
    assign underrun_cnt_o = '0;
`endif

    assign s_tready     = !full;
    assign dac_dat_a_o  = dat_a_q;
    assign dac_dat_b_o  = dat_b_q;
    assign running_o    = running_q;
    assign underrun_o   = underrun_q;
    assign fifo_level_o = level_q;

endmodule

// File: tb/tb_dac_stream_player.sv
// tb_dac_stream_player: scoreboard bench for dac_stream_player.
// Main instance uses a 64-deep FIFO; a second 8-deep instance covers the full case.
module tb_dac_stream_player;

`ifdef DAC_STREAM_PLAYER_UNDERRUN_CNT_EN
    localparam int U1 = 1;
    localparam int U2 = 2;
`else
    localparam int U1 = 0;
    localparam int U2 = 0;
`endif

    logic        clk = 1'b0;
    logic        rst, en, sm_en;
    logic [15:0] rate;
    logic [13:0] off_a, off_b;
    logic [31:0] s_data, sm_data;
    logic        s_valid, sm_valid;
    logic        s_ready, sm_ready;
    logic [13:0] dac_a, dac_b, sm_a, sm_b;
    logic        running, underrun, sm_running, sm_underrun;
    logic [6:0]  level;
    logic [3:0]  sm_level;
    logic [15:0] ucnt, sm_ucnt;

    int n_tests = 0;
    int n_fail  = 0;

    dac_stream_player #(.FIFO_AW(6), .PREFILL(4)) u_dut (
        .dac_clk_1x     (clk),
        .dac_rst        (rst),
        .enable_i       (en),
        .rate_i         (rate),
        .offset_a_i     (off_a),
        .offset_b_i     (off_b),
        .s_tdata        (s_data),
        .s_tvalid       (s_valid),
        .s_tready       (s_ready),
        .dac_dat_a_o    (dac_a),
        .dac_dat_b_o    (dac_b),
        .running_o      (running),
        .underrun_o     (underrun),
        .fifo_level_o   (level),
        .underrun_cnt_o (ucnt)
    );

    dac_stream_player #(.FIFO_AW(3), .PREFILL(4)) u_small (
        .dac_clk_1x     (clk),
        .dac_rst        (rst),
        .enable_i       (sm_en),
        .rate_i         (rate),
        .offset_a_i     (off_a),
        .offset_b_i     (off_b),
        .s_tdata        (sm_data),
        .s_tvalid       (sm_valid),
        .s_tready       (sm_ready),
        .dac_dat_a_o    (sm_a),
        .dac_dat_b_o    (sm_b),
        .running_o      (sm_running),
        .underrun_o     (sm_underrun),
        .fifo_level_o   (sm_level),
        .underrun_cnt_o (sm_ucnt)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] m14(input int v);
        return v[13:0];
    endfunction

    function automatic int sx14(input logic [13:0] v);
        return int'($signed(v));
    endfunction

    function automatic int sat(input int v);
        if (v > 8191) return 8191;
        if (v < -8192) return -8192;
        return v;
    endfunction

    function automatic logic [31:0] pack(input int a, input int b);
        return {2'b00, m14(b), 2'b00, m14(a)};
    endfunction

    function automatic logic [27:0] exp_pair(input logic [31:0] d);
        int a, b;
        a = sat(sx14(d[13:0]) + sx14(off_a));
        b = sat(sx14(d[29:16]) + sx14(off_b));
        return {m14(b), m14(a)};
    endfunction

    // Scoreboard: accepted pushes queue their expected output; modelled
    // ticks pop them, and they must appear at the outputs two cycles later.
    logic [27:0] sb [$];
    logic [27:0] p1, p2;
    logic        p1_v = 1'b0, p2_v = 1'b0;
    logic        en_d1 = 1'b0, en_d2 = 1'b0;
    logic [13:0] exp_a = '0, exp_b = '0;
    int          cnt_m = 0;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            p1_v  = 1'b0;
            p2_v  = 1'b0;
            en_d1 = 1'b0;
            en_d2 = 1'b0;
            cnt_m = 0;
            exp_a = '0;
            exp_b = '0;
        end else begin
            if (!en_d2) begin
                exp_a = '0;
                exp_b = '0;
            end else if (p2_v) begin
                exp_a = p2[13:0];
                exp_b = p2[27:14];
            end
            chk("sb_a", 32'(dac_a), 32'(exp_a));
            chk("sb_b", 32'(dac_b), 32'(exp_b));
            p2   = p1;
            p2_v = p1_v;
            p1_v = 1'b0;
            if (running && en) begin
                if (cnt_m == 0) begin
                    if (sb.size() > 0) begin
                        p1   = sb.pop_front();
                        p1_v = 1'b1;
                    end
                    cnt_m = int'(rate);
                end else begin
                    cnt_m--;
                end
            end else begin
                cnt_m = 0;
            end
            if (!en && en_d1) begin
                sb.delete();
            end else if (s_valid && s_ready) begin
                sb.push_back(exp_pair(s_data));
            end
            en_d2 = en_d1;
            en_d1 = en;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic feed(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            logic ok;
            int   g;
            s_data  = pack(base + i, -(base + i));
            s_valid = 1'b1;
            g = 0;
            do begin
                ok = s_ready;
                step();
                g++;
            end while (!ok && g < 100);
            if (!ok) chk("feed_timeout", 32'(ok), 32'd1);
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_run(input logic want, input int lim, input string tag);
        int k;
        k = 0;
        while (running !== want && k < lim) begin
            step();
            k++;
        end
        chk(tag, 32'(running), 32'(want));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sm_en = 1'b0;
        s_valid = 1'b0; sm_valid = 1'b0;
        s_data = '0; sm_data = '0;
        rate = '0; off_a = '0; off_b = '0;
        step(3);
        rst = 1'b0;
        chk("rst_a", 32'(dac_a), 32'd0);
        chk("rst_b", 32'(dac_b), 32'd0);
        chk("rst_run", 32'(running), 32'd0);
        chk("rst_ur", 32'(underrun), 32'd0);
        chk("rst_lvl", 32'(level), 32'd0);
        chk("rst_ucnt", 32'(ucnt), 32'd0);
        chk("rst_rdy", 32'(s_ready), 32'd1);

        // Preload 4 pairs, then play at rate 0
        for (int i = 1; i <= 4; i++) begin
            s_data  = pack(i, -1);
            s_valid = 1'b1;
            step();
        end
        s_valid = 1'b0;
        chk("t1_lvl", 32'(level), 32'd4);
        en = 1'b1;
        step();
        chk("t1_pre_run", 32'(running), 32'd0);
        chk("t1_pre_a", 32'(dac_a), 32'd0);
        step();
        chk("t1_run", 32'(running), 32'd1);
        chk("t1_run_a", 32'(dac_a), 32'd0);
        step();
        chk("t1_c3_a", 32'(dac_a), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("t1_a", 32'(dac_a), 32'(m14(k)));
            chk("t1_b", 32'(dac_b), 32'h3FFF);
        end
        chk("t1_ur_run", 32'(running), 32'd0);
        chk("t1_ur", 32'(underrun), 32'd1);
        chk("t1_ucnt", 32'(ucnt), 32'(U1));
        en = 1'b0;
        step(2);
        chk("t1_idle_a", 32'(dac_a), 32'd0);
        chk("t1_sticky", 32'(underrun), 32'd1);

        // Hold of 4 cycles, then 2 after a mid-run rate change
        rate = 16'd3;
        en   = 1'b1;
        fork
            feed(30, 100);
            begin
                step(40);
                rate = 16'd1;
            end
        join
        wait_run(1'b0, 300, "t2_drain");
        chk("t2_ur", 32'(underrun), 32'd1);
        chk("t2_ucnt", 32'(ucnt), 32'(U1));
        en = 1'b0;
        step(2);
        rate = '0;

        // Saturation, positive and negative offsets
        off_a = m14(500);
        off_b = m14(-500);
        s_valid = 1'b1;
        s_data = pack(8000, -8000); step();
        s_data = pack(-8000, 8000); step();
        s_data = pack(8191, 8191);  step();
        s_data = pack(0, 0);        step();
        s_valid = 1'b0;
        en = 1'b1;
        step(4);
        chk("t3_sat_hi", 32'(dac_a), 32'(m14(8191)));
        chk("t3_sat_lo", 32'(dac_b), 32'(m14(-8192)));
        step();
        chk("t3_a2", 32'(dac_a), 32'(m14(-7500)));
        chk("t3_b2", 32'(dac_b), 32'(m14(7500)));
        step();
        chk("t3_a3", 32'(dac_a), 32'(m14(8191)));
        chk("t3_b3", 32'(dac_b), 32'(m14(7691)));
        en = 1'b0;
        step(2);
        off_a = m14(-50);
        off_b = m14(50);
        s_valid = 1'b1;
        s_data = pack(100, 0);       step();
        s_data = pack(-8192, 8191);  step();
        s_data = pack(-8150, -8150); step();
        s_data = pack(8191, -8192);  step();
        s_valid = 1'b0;
        en = 1'b1;
        step(4);
        chk("t3_sub_a", 32'(dac_a), 32'(m14(50)));
        chk("t3_sub_b", 32'(dac_b), 32'(m14(50)));
        step();
        chk("t3_min_a", 32'(dac_a), 32'(m14(-8192)));
        chk("t3_max_b", 32'(dac_b), 32'(m14(8191)));
        step();
        chk("t3_neg_a", 32'(dac_a), 32'(m14(-8192)));
        chk("t3_neg_b", 32'(dac_b), 32'(m14(-8100)));
        step();
        chk("t3_end_a", 32'(dac_a), 32'(m14(8141)));
        chk("t3_end_b", 32'(dac_b), 32'(m14(-8142)));
        en = 1'b0;
        step(2);
        off_a = '0;
        off_b = '0;

        // Underrun after 10 pairs, resume after 4 more
        en = 1'b1;
        feed(10, 1000);
        wait_run(1'b0, 100, "t4_stop");
        step(3);
        chk("t4_hold_a", 32'(dac_a), 32'(m14(1009)));
        chk("t4_hold_b", 32'(dac_b), 32'(m14(-1009)));
        chk("t4_ur", 32'(underrun), 32'd1);
        chk("t4_run", 32'(running), 32'd0);
        chk("t4_ucnt", 32'(ucnt), 32'(U1));
        feed(4, 2000);
        wait_run(1'b1, 20, "t4_resume");
        wait_run(1'b0, 50, "t4_stop2");
        step(3);
        chk("t4_ucnt2", 32'(ucnt), 32'(U2));
        chk("t4_hold2", 32'(dac_a), 32'(m14(2003)));

        // Disable mid-run at level 20; re-enable clears underrun
        en = 1'b0;
        step(2);
        chk("t5_sticky", 32'(underrun), 32'd1);
        feed(22, 3000);
        chk("t5_pre_lvl", 32'(level), 32'd22);
        rate = 16'd3;
        en = 1'b1;
        step();
        chk("t5_ur_clr", 32'(underrun), 32'd0);
        chk("t5_ucnt_clr", 32'(ucnt), 32'd0);
        step(6);
        chk("t5_lvl20", 32'(level), 32'd20);
        chk("t5_running", 32'(running), 32'd1);
        en = 1'b0;
        s_data = pack(77, 77);
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        chk("t5_off_run", 32'(running), 32'd0);
        chk("t5_flush", 32'(level), 32'd0);
        step();
        chk("t5_zero_a", 32'(dac_a), 32'd0);
        chk("t5_zero_b", 32'(dac_b), 32'd0);
        chk("t5_discard", 32'(level), 32'd0);
        rate = '0;

        // Small FIFO: full at 8, ninth accepted only after a pop
        for (int i = 1; i <= 8; i++) begin
            chk("t6_rdy", 32'(sm_ready), 32'd1);
            sm_data  = pack(i, 0);
            sm_valid = 1'b1;
            step();
        end
        sm_data = pack(9, 0);
        chk("t6_full", 32'(sm_ready), 32'd0);
        chk("t6_lvl8", 32'(sm_level), 32'd8);
        step(2);
        chk("t6_hold", 32'(sm_level), 32'd8);
        sm_en = 1'b1;
        step(3);
        chk("t6_rdy_pop", 32'(sm_ready), 32'd1);
        chk("t6_lvl7", 32'(sm_level), 32'd7);
        step();
        sm_valid = 1'b0;
        chk("t6_a1", 32'(sm_a), 32'd1);
        chk("t6_lvl_pp", 32'(sm_level), 32'd7);
        for (int k = 2; k <= 9; k++) begin
            step();
            chk("t6_a", 32'(sm_a), 32'(k));
        end
        sm_en = 1'b0;
        step(2);

        // Reset in the middle of playback
        feed(8, 500);
        en = 1'b1;
        step(5);
        rst = 1'b1;
        en  = 1'b0;
        step();
        chk("t7_a", 32'(dac_a), 32'd0);
        chk("t7_run", 32'(running), 32'd0);
        chk("t7_lvl", 32'(level), 32'd0);
        chk("t7_rdy", 32'(s_ready), 32'd1);
        rst = 1'b0;
        step(2);
        chk("t7_post_a", 32'(dac_a), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_stream_player.md
Name: dac_stream_player

Overview:
- Streaming sample source directly upstream of the DAC IC interface stage.
- Accepts packed two-channel samples over a valid/ready stream from DMA/BRAM logic and buffers them in an internal FIFO.
- Releases one sample pair every rate_i+1 cycles, applies per-channel signed offset with saturation, and drives the 14-bit signed dac_dat_a/dac_dat_b inputs of the DAC interface.
- Handles prefill, underrun and enable/disable sequencing.

Parameters:
- FIFO_AW, 9, FIFO address width; depth = 2**FIFO_AW sample pairs.
- PREFILL, 256, FIFO level required before playback starts or resumes; legal range 1..2**FIFO_AW.

Ports:
- dac_clk_1x  in  1  DAC sample clock; sole clock of the block.
- dac_rst  in  1  synchronous, active-high reset.
- enable_i  in  1  playback enable; level-sensitive.
- rate_i  in  16  hold count; each sample pair is presented for rate_i+1 cycles.
- offset_a_i  in  14  signed offset added to channel A.
- offset_b_i  in  14  signed offset added to channel B.
- s_tdata  in  32  [13:0] = channel A signed, [29:16] = channel B signed; bits [15:14] and [31:30] ignored.
- s_tvalid  in  1  stream data valid.
- s_tready  out  1  stream ready; equals !fifo_full.
- dac_dat_a_o  out  14  signed channel A sample to the DAC interface.
- dac_dat_b_o  out  14  signed channel B sample to the DAC interface.
- running_o  out  1  high while in the RUN state.
- underrun_o  out  1  sticky underrun flag.
- fifo_level_o  out  FIFO_AW+1  current FIFO occupancy.
- underrun_cnt_o  out  16  underrun event count (see Optional Feature).

Behaviour:
- Single clock dac_clk_1x; dac_rst is synchronous and active-high; all state is registered on the rising edge.
- Reset values:
  - state = IDLE; FIFO empty.
  - dac_dat_a_o = 0, dac_dat_b_o = 0.
  - running_o = 0, underrun_o = 0, fifo_level_o = 0, underrun_cnt_o = 0.
  - s_tready = 1 in the first cycle after reset.
- Push and pop:
  - Push occurs when s_tvalid && s_tready.
  - Push and pop in the same cycle: both happen; level unchanged.
  - A full FIFO never accepts a push (s_tready = 0).
  - fifo_level_o is registered; it reflects the pushes and pops of the previous cycle.
- Rate counter:
  - Loads rate_i on each tick and decrements to 0; a tick fires when the count is 0.
  - rate_i = 0 gives a tick every cycle.
  - A change to rate_i takes effect at the next reload.
- States:
  - IDLE: outputs driven to 0. FIFO accepts pushes (preload allowed). enable_i=1 -> PREFILL.
  - PREFILL: outputs hold 0. When level >= PREFILL -> RUN; the counter is loaded with 0, so the first tick occurs in the first RUN cycle.
  - RUN: a pop occurs on each tick.
    - Tick with FIFO empty -> UNDERRUN; set underrun_o; increment the underrun counter.
  - UNDERRUN: outputs hold the last value. When level >= PREFILL -> RUN.
  - enable_i=0 in any state -> IDLE next cycle:
    - The FIFO is flushed (level 0) in the same transition.
    - Outputs are 0 from the following cycle.
    - A push presented in the flush cycle is discarded.
- Output pipeline:
  - Pop at cycle T; FIFO read data is registered at T+1; the saturated sum is registered at the output at T+2.
  - Outputs hold between pops.
- Arithmetic:
  - 15-bit signed sum = sample + offset.
  - Clamp to the range -8192..8191.
- underrun_o clears only on dac_rst or on an IDLE->PREFILL transition.
- running_o is registered and is high in exactly the cycles the state is RUN.
- Reset asserted mid-stream: all state returns to reset values in the next cycle; no partial sample is emitted.

Optional Feature:
- Macro: DAC_STREAM_PLAYER_UNDERRUN_CNT_EN.
- Defined:
  - 16-bit counter increments on each RUN->UNDERRUN transition.
  - Saturates at 0xFFFF.
  - Clears like underrun_o.
- Undefined: counter logic is omitted and underrun_cnt_o is tied to 0.
- All other behaviour is identical with or without the macro.

Test Plan:
- Reset, then preload 4 pairs A=0x0001..0x0004, B=-1, with PREFILL=4, rate_i=0, offsets 0, enable_i=1:
  - Outputs 0 before the first pop.
  - Then A = 1,2,3,4 on consecutive cycles starting 2 cycles after the first RUN cycle; B = 0x3FFF throughout.
- rate_i=3 with a continuous stream: each output value is held exactly 4 cycles; changing rate_i to 1 mid-run gives a 2-cycle hold starting after the next tick.
- Saturation:
  - Sample A=8000 with offset_a_i=500 -> 8191.
  - Sample B=-8000 with offset_b_i=-500 -> -8192.
  - Sample A=100 with offset_a_i=-50 -> 50.
- Underrun: stop s_tvalid after 10 pairs with PREFILL=4:
  - Last value held; underrun_o=1; running_o=0; underrun_cnt_o=1 (macro defined, 0 if undefined).
  - After 4 more pushes, playback resumes.
- Full FIFO with FIFO_AW=3 and enable_i=0: push 9 pairs -> s_tready drops after the 8th push; fifo_level_o=8; the 9th pair is accepted only after a pop.
- enable_i dropped mid-run with FIFO level 20 -> next cycle state IDLE and level 0; outputs 0 the cycle after; a later re-enable clears underrun_o.
